riscv_mem_arbiter: RTL and testbench

- Shares one single-port memory/bus slave between the core's instruction-fetch port and its load/store port.
- Fixed priority to data, with a bounded-starvation override for fetch.
- Routes in-order read/write responses back to their originator through a small owner FIFO.
- Sits between the core pipeline and the unified memory inside riscv_top.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/riscv_arb_owner_fifo.sv | 76 +++++++
 rtl/riscv_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: arbitration selection and response-owner tags.
package riscv_pkg;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_FETCH = 2'd1,
        SEL_DATA  = 2'd2
    } arb_sel_e;

endpackage

// File: rtl/riscv_arb_owner_fifo.sv
// In-order owner tag FIFO: remembers which port each granted memory transaction
// belongs to so responses can be routed back.
module riscv_arb_owner_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk_sys_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  owner_e push_owner_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_e head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_e             mem_q [DEPTH];
    owner_e             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push_i) begin
            mem_d[wr_ptr_q] = push_owner_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= OWN_FETCH;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Fetch/data arbiter for a single-port memory: data has priority, fetch wins after
// MAX_STARVE consecutive losses; responses are routed back via the owner FIFO.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_OUT    = 2,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                clk_sys_i,
    input  logic                rst_i,

    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,

    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                err_o
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

    arb_sel_e            sel;
    logic                grant;
    logic                fifo_push;
    owner_e              fifo_push_owner;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    owner_e              fifo_head;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                err_q, err_d;

    riscv_arb_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk_sys_i    (clk_sys_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_owner_i (fifo_push_owner),
        .pop_i        (fifo_pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

    // Arbitration, request mux and grant generation.
    always_comb begin
        sel = SEL_NONE;
        if (if_req_i && (!d_req_i || (starve_q == STARVE_W'(MAX_STARVE)))) begin
            sel = SEL_FETCH;
        end else if (d_req_i) begin
            sel = SEL_DATA;
        end

        // No new grants while reset is held: the FIFO cannot record their owners.
        mem_req_o   = (sel != SEL_NONE) && !fifo_full && !rst_i;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (sel)
            SEL_FETCH: begin
                mem_be_o   = {BE_W{1'b1}};
                mem_addr_o = if_addr_i;
            end
            SEL_DATA: begin
                mem_we_o    = d_we_i;
                mem_be_o    = d_be_i;
                mem_addr_o  = d_addr_i;
                mem_wdata_o = d_wdata_i;
            end
            default: ;
        endcase

        grant           = mem_req_o && mem_gnt_i;
        if_gnt_o        = grant && (sel == SEL_FETCH);
        d_gnt_o         = grant && (sel == SEL_DATA);
        fifo_push       = grant;
        fifo_push_owner = (sel == SEL_DATA) ? OWN_DATA : OWN_FETCH;
    end

    // Response routing from the FIFO head.
    always_comb begin
        fifo_pop    = mem_rvalid_i && !fifo_empty;
        if_rvalid_o = fifo_pop && (fifo_head == OWN_FETCH);
        d_rvalid_o  = fifo_pop && (fifo_head == OWN_DATA);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
    end

    // Starvation counter and sticky error.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_o) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(MAX_STARVE)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        err_d = err_q || (mem_rvalid_i && fifo_empty);
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with hand-computed expectations.
module tb_riscv_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic               clk_sys_i;
    logic               rst_i;
    logic               if_req_i;
    logic [ADDR_W-1:0]  if_addr_i;
    logic               if_gnt_o;
    logic               if_rvalid_o;
    logic [DATA_W-1:0]  if_rdata_o;
    logic               d_req_i;
    logic               d_we_i;
    logic [3:0]         d_be_i;
    logic [ADDR_W-1:0]  d_addr_i;
    logic [DATA_W-1:0]  d_wdata_i;
    logic               d_gnt_o;
    logic               d_rvalid_o;
    logic [DATA_W-1:0]  d_rdata_o;
    logic               mem_req_o;
    logic               mem_we_o;
    logic [3:0]         mem_be_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [DATA_W-1:0]  mem_wdata_o;
    logic               mem_gnt_i;
    logic               mem_rvalid_i;
    logic [DATA_W-1:0]  mem_rdata_i;
    logic               err_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_OUT    (2),
        .MAX_STARVE (4)
    ) dut (
        .clk_sys_i    (clk_sys_i),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_be_i       (d_be_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_o        (err_o)
    );

    initial begin
        clk_sys_i = 1'b0;
        forever #5 clk_sys_i = ~clk_sys_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_sys_i);
        #1;
    endtask

    task automatic idle();
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_be_i       = '0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_memreq"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_ifgnt"}, 32'(if_gnt_o), 32'd0);
        chk({tag, "_dgnt"}, 32'(d_gnt_o), 32'd0);
        chk({tag, "_ifrv"}, 32'(if_rvalid_o), 32'd0);
        chk({tag, "_drv"}, 32'(d_rvalid_o), 32'd0);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        #1;
        chk_quiet("rst");
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Fetch only, response one cycle later.
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        mem_gnt_i = 1'b1;
        #1;
        chk("f_gnt", 32'(if_gnt_o), 32'd1);
        chk("f_dgnt", 32'(d_gnt_o), 32'd0);
        chk("f_addr", mem_addr_o, 32'h0000_0100);
        chk("f_be", 32'(mem_be_o), 32'hF);
        chk("f_we", 32'(mem_we_o), 32'd0);
        tick();
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_0013;
        #1;
        chk("f_rv", 32'(if_rvalid_o), 32'd1);
        chk("f_rdata", if_rdata_o, 32'h0000_0013);
        chk("f_drv", 32'(d_rvalid_o), 32'd0);
        chk("f_drdata", d_rdata_o, 32'd0);
        tick();
        idle();
        #1;
        chk_quiet("idle");

        // Both requesting: DDDDF repeating; each cycle returns the previous grant.
        for (int i = 0; i < 10; i++) begin
            if_req_i     = 1'b1;
            if_addr_i    = 32'h0000_1000;
            d_req_i      = 1'b1;
            d_addr_i     = 32'h0000_2000;
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = 32'(i);
            #1;
            chk($sformatf("st_ifgnt%0d", i), 32'(if_gnt_o), 32'((i % 5) == 4));
            chk($sformatf("st_dgnt%0d", i), 32'(d_gnt_o), 32'((i % 5) != 4));
            if (i > 0) begin
                chk($sformatf("st_ifrv%0d", i), 32'(if_rvalid_o), 32'(((i - 1) % 5) == 4));
                chk($sformatf("st_drv%0d", i), 32'(d_rvalid_o), 32'(((i - 1) % 5) != 4));
            end
            tick();
        end
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hAAAA_0009;
        #1;
        chk("st_drain_ifrv", 32'(if_rvalid_o), 32'd1);
        chk("st_drain_ifrdata", if_rdata_o, 32'hAAAA_0009);
        tick();
        idle();

        // Owner FIFO full blocks a third request until a response arrives.
        d_req_i   = 1'b1;
        d_addr_i  = 32'h0000_0200;
        mem_gnt_i = 1'b1;
        #1;
        chk("full_g0", 32'(d_gnt_o), 32'd1);
        tick();
        d_addr_i = 32'h0000_0204;
        #1;
        chk("full_g1", 32'(d_gnt_o), 32'd1);
        tick();
        d_addr_i = 32'h0000_0208;
        #1;
        chk("full_req2", 32'(mem_req_o), 32'd0);
        chk("full_gnt2", 32'(d_gnt_o), 32'd0);
        tick();
        #1;
        chk("full_req3", 32'(mem_req_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_0001;
        #1;
        chk("full_req4", 32'(mem_req_o), 32'd0);
        chk("full_drv4", 32'(d_rvalid_o), 32'd1);
        chk("full_drdata4", d_rdata_o, 32'hDEAD_0001);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chk("full_req5", 32'(mem_req_o), 32'd1);
        chk("full_gnt5", 32'(d_gnt_o), 32'd1);
        chk("full_addr5", mem_addr_o, 32'h0000_0208);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            mem_rvalid_i = 1'b1;
            #1;
            chk($sformatf("full_drain%0d", i), 32'(d_rvalid_o), 32'd1);
            tick();
        end
        idle();

        // Interleaved F, D(write), F with in-order responses.
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0300;
        mem_gnt_i = 1'b1;
        #1;
        chk("il_g0", 32'(if_gnt_o), 32'd1);
        tick();
        idle();
        d_req_i      = 1'b1;
        d_we_i       = 1'b1;
        d_be_i       = 4'b0011;
        d_addr_i     = 32'h0000_0400;
        d_wdata_i    = 32'h1234_5678;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00A1;
        #1;
        chk("il_g1", 32'(d_gnt_o), 32'd1);
        chk("il_we", 32'(mem_we_o), 32'd1);
        chk("il_be", 32'(mem_be_o), 32'h3);
        chk("il_wdata", mem_wdata_o, 32'h1234_5678);
        chk("il_rv0_if", 32'(if_rvalid_o), 32'd1);
        chk("il_rv0_d", 32'(d_rvalid_o), 32'd0);
        tick();
        idle();
        if_req_i     = 1'b1;
        if_addr_i    = 32'h0000_0304;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00B2;
        #1;
        chk("il_g2", 32'(if_gnt_o), 32'd1);
        chk("il_rv1_d", 32'(d_rvalid_o), 32'd1);
        chk("il_rv1_if", 32'(if_rvalid_o), 32'd0);
        chk("il_rv1_drdata", d_rdata_o, 32'h0000_00B2);
        tick();
        idle();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0000_00C3;
        #1;
        chk("il_rv2_if", 32'(if_rvalid_o), 32'd1);
        chk("il_rv2_ifrdata", if_rdata_o, 32'h0000_00C3);
        tick();
        idle();

        // Response with an empty FIFO sets the sticky error.
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        chk("err_ifrv", 32'(if_rvalid_o), 32'd0);
        chk("err_drv", 32'(d_rvalid_o), 32'd0);
        chk("err_pre", 32'(err_o), 32'd0);
        tick();
        idle();
        #1;
        chk("err_set", 32'(err_o), 32'd1);
        tick();
        tick();
        #1;
        chk("err_hold", 32'(err_o), 32'd1);

        // Asynchronous reset with two outstanding transactions.
        d_req_i   = 1'b1;
        d_addr_i  = 32'h0000_0500;
        mem_gnt_i = 1'b1;
        tick();
        tick();
        #1;
        chk("rr_full", 32'(mem_req_o), 32'd0);
        mem_rvalid_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk_quiet("rr");
        chk("rr_err", 32'(err_o), 32'd0);
        tick();
        idle();
        rst_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        #1;
        chk("rr_stale_drv", 32'(d_rvalid_o), 32'd0);
        tick();
        idle();
        #1;
        chk("rr_stale_err", 32'(err_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
